instr_issue_queue: RTL and testbench
====================================

// Module: instr_issue_queue
// PURPOSE
//   Instruction feeder upstream of the snooping-coherence top (3 caches + memory + bus).
//   Buffers 10-bit coherence instructions {op[9], proc[8:7], tag[6:4], value[3:0]} in a FIFO.
//   Presents exactly one instruction per 4-step bus transaction, aligned to the shared 2-bit step counter.
//   Instruc stays stable for all four steps of its transaction window.
// PARAMETERS
//   DEPTH    8   FIFO entries; power of 2, >= 2
//   INSTR_W  10  instruction width; fixed field layout above
//   CNT_W    $clog2(DEPTH+1)  occupancy counter width (localparam)
// PORTS
//   clock        in   1        single system clock, rising edge
//   reset        in   1        synchronous, active-high
//   step         in   2        shared transaction step counter (0,1,2,3 repeating)
//   in_valid     in   1        producer offers in_instr this cycle
//   in_instr     in   INSTR_W  instruction to enqueue
//   in_ready     out  1        queue can accept; = !full
//   Instruc      out  INSTR_W  instruction presented to the caches (registered)
//   issue_valid  out  1        Instruc holds a fresh instruction for the current window
//   count        out  CNT_W    entries currently queued (excludes the one being presented)
//   full         out  1        count == DEPTH
//   empty        out  1        count == 0
//   err_invalid  out  1        sticky: an instruction with proc==2'b11 was dropped
//   drop_cnt     out  8        number of dropped instructions, saturates at 255
// BEHAVIOUR
//   - Reset (sync, any cycle, including mid-window): rd/wr pointers=0, count=0, Instruc=0,
//     issue_valid=0, full=0, empty=1, in_ready=1, err_invalid=0, drop_cnt=0; queue contents discarded.
//   - Push: in_valid && in_ready at a rising edge writes in_instr at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//   - Pop/issue: only on the edge where step==2'b11.
//     non-empty -> Instruc<=head, issue_valid<=1, rd_ptr++ (wraps).
//     empty     -> Instruc holds its previous value, issue_valid<=0.
//   - New instruction is therefore visible from step 0 through step 3 of the next window.
//     Latency for an enqueue into an empty queue: the next step==3 edge, i.e. 1 to 4 cycles.
//   - Push on an edge with step!=3: count+1.
//   - Simultaneous push and pop (step==3, non-empty): count unchanged; FIFO order preserved.
//   - No bypass: a push into an empty queue on a step==3 edge is not issued on that edge.
//     It is issued at the next step==3 edge.
//   - Full: in_ready=0; any offered push is ignored, even when a pop occurs on the same edge.
//     The freed slot is visible one cycle later.
//   - Overflow is impossible by construction. Underflow cannot occur: no pop when empty.
//   - full/empty/in_ready are derived combinationally from registered count.
// CONFIGURATION
//   ISSUE_CHECK_EN defined:
//     A push with in_instr[8:7]==2'b11 (no such processor) is accepted but not enqueued.
//     in_ready is unaffected, so the handshake still completes.
//     drop_cnt increments, saturating at 255; err_invalid sets and stays 1 until reset.
//   ISSUE_CHECK_EN undefined:
//     All pushes are enqueued unchanged.
//     err_invalid is tied to 0 and drop_cnt is tied to 0; the ports are still present.
// TESTING
//   1. Assert reset 2 cycles -> empty=1, full=0, count=0, issue_valid=0, Instruc=0, in_ready=1.
//   2. Push 10'b1_01_010_0110 at step 1 -> count=1; after the step-3 edge Instruc=10'b1010100110,
//      issue_valid=1 for steps 0-3, count=0.
//   3. Hold step=0 and push 9 instructions back-to-back -> full=1 after the 8th push, in_ready=0,
//      9th ignored, count=8; then 8 windows issue them in order, then issue_valid=0.
//   4. count=3, push on the step-3 edge -> count stays 3; the issued order matches the push order exactly.
//   5. Queue empties; at the next step-3 edge issue_valid falls to 0 and Instruc keeps its last value.
//      Assert reset at step 2 with count=5 -> all state cleared on that edge.
//   6. ISSUE_CHECK_EN defined: push 10'b0_11_001_0001 -> not enqueued, count=0, drop_cnt=1,
//      err_invalid=1 held until reset; undefined: the same push is enqueued and err_invalid stays 0.

Source files
------------

// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//   Instruction feeder for the snooping-coherence system. Buffers 10-bit
//   coherence instructions {op[9], proc[8:7], tag[6:4], value[3:0]} in a FIFO.
//   It presents one instruction per 4-step bus transaction. The pop happens on
//   the edge where step==3. The presented instruction then stays stable on
//   Instruc for steps 0..3 of the following window.
//
//   Optional feature macro: ISSUE_CHECK_EN
//     defined   : pushes addressing proc==2'b11 are accepted but discarded;
//                 drop_cnt counts them (saturating) and err_invalid latches.
//     undefined : every push is enqueued; err_invalid and drop_cnt read 0.
//
// Ports
//   clock        in   1        system clock, rising edge
//   reset        in   1        synchronous, active-high
//   step         in   2        shared transaction step counter
//   in_valid     in   1        producer offers in_instr
//   in_instr     in   INSTR_W  instruction to enqueue
//   in_ready     out  1        queue can accept (= !full)
//   Instruc      out  INSTR_W  registered instruction presented to the caches
//   issue_valid  out  1        Instruc is fresh for the current window
//   count        out  CNT_W    queued entries (excludes the presented one)
//   full         out  1        count == DEPTH
//   empty        out  1        count == 0
//   err_invalid  out  1        sticky invalid-processor drop flag
//   drop_cnt     out  8        dropped instruction count, saturating at 255
// -----------------------------------------------------------------------------
module instr_issue_queue #(
  parameter  int DEPTH   = 8,
  parameter  int INSTR_W = 10,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         step,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic [INSTR_W-1:0] Instruc,
  output logic               issue_valid,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               err_invalid,
  output logic [7:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               drop;
  logic               enq;
  logic               pop;
  logic               issue_edge;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign issue_edge = (step == 2'b11);
  // No bypass: pop looks only at registered occupancy, so an entry pushed on
  // the issue edge waits for the next window.
  assign pop        = issue_edge && !empty;

`ifdef ISSUE_CHECK_EN
  assign drop = push && (in_instr[8:7] == 2'b11);
`else
  assign drop = 1'b0;
`endif

  assign enq = push && !drop;

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      Instruc     <= '0;
      issue_valid <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);

      if (issue_edge) begin
        issue_valid <= pop;
        if (pop) begin
          Instruc <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + PTR_W'(1);
        end
      end

      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ISSUE_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_invalid <= 1'b0;
      drop_cnt    <= '0;
    end else if (drop) begin
      err_invalid <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign err_invalid = 1'b0;
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
//   Self-checking bench for instr_issue_queue. Expected issue order is kept in
//   a scoreboard queue: entries are pushed when an accepted enqueue is driven
//   and popped when a step==3 edge should issue them.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

  localparam int DEPTH   = 8;
  localparam int INSTR_W = 10;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic [1:0]         step;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic [INSTR_W-1:0] Instruc;
  logic               issue_valid;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               err_invalid;
  logic [7:0]         drop_cnt;

  instr_issue_queue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .Instruc     (Instruc),
    .issue_valid (issue_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .err_invalid (err_invalid),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  int unsigned        n_vec = 0;
  int unsigned        n_bad = 0;
  logic [INSTR_W-1:0] sb[$];
  logic [INSTR_W-1:0] exp_instr;
  logic               exp_valid;
  logic               exp_err;
  logic [7:0]         exp_drop;
  logic [1:0]         gstep;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("count",       32'(count),       32'(sb.size()));
    check_eq("full",        32'(full),        32'(sb.size() == DEPTH));
    check_eq("empty",       32'(empty),       32'(sb.size() == 0));
    check_eq("in_ready",    32'(in_ready),    32'(sb.size() != DEPTH));
    check_eq("issue_valid", 32'(issue_valid), 32'(exp_valid));
    check_eq("Instruc",     32'(Instruc),     32'(exp_instr));
    check_eq("err_invalid", 32'(err_invalid), 32'(exp_err));
    check_eq("drop_cnt",    32'(drop_cnt),    32'(exp_drop));
  endtask

  // One clock with the given inputs; the model is updated from pre-edge state.
  task automatic cyc(input logic v, input logic [INSTR_W-1:0] d, input logic [1:0] s);
    logic was_full;
    logic bad_proc;
    reset    = 1'b0;
    in_valid = v;
    in_instr = d;
    step     = s;
    was_full = (sb.size() == DEPTH);
    bad_proc = 1'b0;
`ifdef ISSUE_CHECK_EN
    bad_proc = (d[8:7] == 2'b11);
`endif
    if (s == 2'b11) begin
      if (sb.size() != 0) begin
        exp_instr = sb.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (v && !was_full) begin
      if (bad_proc) begin
        exp_err = 1'b1;
        if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      end else begin
        sb.push_back(d);
      end
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic rst_cyc(input logic [1:0] s);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_instr = 10'b1_00_111_1111;
    step     = s;
    sb.delete();
    exp_instr = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_drop  = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  task automatic adv(input logic v, input logic [INSTR_W-1:0] d);
    cyc(v, d, gstep);
    gstep = gstep + 2'd1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) adv(1'b0, '0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    step     = 2'b00;
    exp_instr = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_drop  = '0;

    // Reset held two cycles.
    rst_cyc(2'b00);
    rst_cyc(2'b01);

    // Single push at step 1, issued on the step-3 edge, held for a window.
    gstep = 2'b00;
    adv(1'b0, '0);
    adv(1'b1, 10'b1_01_010_0110);
    idle(2);
    check_eq("t2_instr", 32'(Instruc), 32'h2A6);
    idle(8);

    // Hold step 0 and offer nine pushes; the ninth is refused.
    for (int unsigned i = 0; i < 9; i++)
      cyc(1'b1, INSTR_W'(10'h040 + i), 2'b00);
    check_eq("t3_count", 32'(count), 32'(DEPTH));
    gstep = 2'b01;
    // Pushes offered while full are ignored even on a popping edge.
    idle(2);
    adv(1'b1, 10'h3C5);
    idle(8 * 4 + 4);

    // count=3 then push on the step-3 edge: count stays 3, order preserved.
    for (int unsigned i = 0; i < 3; i++)
      cyc(1'b1, INSTR_W'(10'h100 + i), 2'b00);
    cyc(1'b1, 10'h1AA, 2'b11);
    check_eq("t4_count", 32'(count), 32'd3);
    gstep = 2'b00;
    idle(4 * 4 + 4);

    // No bypass: a push into an empty queue on the step-3 edge waits a window.
    gstep = 2'b11;
    adv(1'b1, 10'h155);
    idle(8);

    // Reset at step 2 with five queued entries.
    for (int unsigned i = 0; i < 5; i++)
      cyc(1'b1, INSTR_W'(10'h200 + i), 2'b00);
    cyc(1'b0, '0, 2'b01);
    rst_cyc(2'b10);
    gstep = 2'b11;
    idle(5);

    // Invalid processor field.
    adv(1'b1, 10'b0_11_001_0001);
    idle(3);
    adv(1'b1, 10'b0_01_001_0001);
    idle(8);
    rst_cyc(gstep);
    gstep = gstep + 2'd1;

    // Random traffic with a free-running step.
    for (int unsigned i = 0; i < 200; i++)
      adv(($urandom_range(0, 2) != 0), INSTR_W'($urandom));
    idle(4 * DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
